passcode_fsm: RTL and testbench

- Consumes single-cycle key pulses from four upstream button pulse-shaping stages, one per key.
- Collects a CODE_LEN-digit entry and compares it against a fixed code.
- Drives a timed unlock output.
- Counts consecutive failures; after MAX_FAIL failures it enters a timed lockout.
- Sits between the button front end and the lock/LED output logic of the passcode design.

---
 rtl/passcode_pkg.sv | 36 +++
 rtl/passcode_if.sv | 23 ++
 rtl/passcode_timer.sv | 35 +++
 rtl/passcode_fsm.sv | 144 ++++++++++++++
 tb/tb_passcode_fsm.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/passcode_pkg.sv
// Shared types and helpers for the passcode entry block.
// Key decode turns a key_pulse vector into an index plus a multi-press flag.
package passcode_pkg;

  localparam int KEY_W    = 2;
  localparam int NUM_KEYS = 4;

  typedef enum logic [1:0] {
    ENTRY    = 2'd0,
    UNLOCKED = 2'd1,
    LOCKOUT  = 2'd2
  } state_e;

  typedef struct packed {
    logic              multi;
    logic [KEY_W-1:0]  index;
  } key_dec_t;

  // index is meaningful only when exactly one bit is set; multi flags two or more
  function automatic key_dec_t onehot_to_index(input logic [NUM_KEYS-1:0] onehot);
    key_dec_t r;
    int       hits;
    r.index = '0;
    r.multi = 1'b0;
    hits    = 0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (onehot[i]) begin
        r.index = KEY_W'(i);
        hits++;
      end
    end
    r.multi = (hits > 1);
    return r;
  endfunction

endpackage

// File: rtl/passcode_if.sv
// Key input and status outputs of the passcode block, grouped as one bundle.
// The slave side is the passcode block; the master side is the front end / consumer.
interface passcode_if;
  import passcode_pkg::*;

  logic [NUM_KEYS-1:0] key_pulse;
  logic                unlocked;
  logic                fail;
  logic                locked_out;
  logic [2:0]          digit_count;
  logic [3:0]          fail_count;

  modport master (
    output key_pulse,
    input  unlocked, fail, locked_out, digit_count, fail_count
  );

  modport slave (
    input  key_pulse,
    output unlocked, fail, locked_out, digit_count, fail_count
  );

endinterface

// File: rtl/passcode_timer.sv
// Loadable saturating down-counter; done is high while the count sits at zero.
// A duration of N cycles is obtained by loading N-1.
module passcode_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/passcode_fsm.sv
// Passcode entry controller: collects CODE_LEN key digits, unlocks on a match,
// counts consecutive failures and locks out after MAX_FAIL of them.
module passcode_fsm
  import passcode_pkg::*;
#(
  parameter int                      CODE_LEN       = 4,
  parameter logic [2*CODE_LEN-1:0]   CODE           = 8'b10_00_01_11,
  parameter int                      MAX_FAIL       = 3,
  parameter int                      UNLOCK_CYCLES  = 16,
  parameter int                      LOCK_CYCLES    = 32,
  parameter int                      TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       clr,
  passcode_if.slave  bus
);

  localparam logic [1:0] S_ENTRY    = ENTRY;
  localparam logic [1:0] S_UNLOCKED = UNLOCKED;
  localparam logic [1:0] S_LOCKOUT  = LOCKOUT;

  localparam int MAX_UL  = (UNLOCK_CYCLES > LOCK_CYCLES) ? UNLOCK_CYCLES : LOCK_CYCLES;
  localparam int MAX_CYC = (MAX_UL > TIMEOUT_CYCLES) ? MAX_UL : TIMEOUT_CYCLES;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  logic [1:0]    state_q, state_d;
  logic [2:0]    digit_count_q, digit_count_d;
  logic [3:0]    fail_count_q, fail_count_d;
  logic          mismatch_q, mismatch_d;
  logic          fail_q, fail_d;
  logic          unlocked_q, unlocked_d;
  logic          locked_out_q, locked_out_d;

  logic          t_load, t_en, t_done;
  logic [TW-1:0] t_val;
  key_dec_t      dec;
  logic          key_ev, wrong_digit;
  logic [KEY_W-1:0] exp_digit;

  passcode_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .clr      (clr),
    .load     (t_load),
    .load_val (t_val),
    .en       (t_en),
    .done     (t_done)
  );

  always_comb begin
    state_d       = state_q;
    digit_count_d = digit_count_q;
    fail_count_d  = fail_count_q;
    mismatch_d    = mismatch_q;
    fail_d        = 1'b0;
    t_load        = 1'b0;
    t_en          = 1'b0;
    t_val         = TW'(TIMEOUT_CYCLES - 1);

    dec         = onehot_to_index(bus.key_pulse);
    key_ev      = |bus.key_pulse;
    exp_digit   = CODE[int'(digit_count_q) * KEY_W +: KEY_W];
    wrong_digit = dec.multi || (dec.index != exp_digit);

    case (state_q)
      S_ENTRY: begin
        if (key_ev) begin
          t_load = 1'b1;
          if (digit_count_q == 3'(CODE_LEN - 1)) begin
            digit_count_d = '0;
            mismatch_d    = 1'b0;
            if (!(mismatch_q || wrong_digit)) begin
              state_d      = S_UNLOCKED;
              fail_count_d = '0;
              t_val        = TW'(UNLOCK_CYCLES - 1);
            end else begin
              fail_d = 1'b1;
              if ((5'(fail_count_q) + 5'd1) >= 5'(MAX_FAIL)) begin
                state_d      = S_LOCKOUT;
                fail_count_d = 4'(MAX_FAIL);
                t_val        = TW'(LOCK_CYCLES - 1);
              end else begin
                fail_count_d = fail_count_q + 4'd1;
              end
            end
          end else begin
            digit_count_d = digit_count_q + 3'd1;
            mismatch_d    = mismatch_q | wrong_digit;
          end
        end else if (digit_count_q != '0) begin
          // Idle timer only runs while a partial entry is pending
          if (t_done) begin
            digit_count_d = '0;
            mismatch_d    = 1'b0;
          end else begin
            t_en = 1'b1;
          end
        end
      end
      S_UNLOCKED: begin
        if (t_done) state_d = S_ENTRY;
        else        t_en    = 1'b1;
      end
      S_LOCKOUT: begin
        if (t_done) begin
          state_d      = S_ENTRY;
          fail_count_d = '0;
        end else begin
          t_en = 1'b1;
        end
      end
      default: state_d = S_ENTRY;
    endcase

    unlocked_d   = (state_d == S_UNLOCKED);
    locked_out_d = (state_d == S_LOCKOUT);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q       <= S_ENTRY;
      digit_count_q <= '0;
      fail_count_q  <= '0;
      mismatch_q    <= 1'b0;
      fail_q        <= 1'b0;
      unlocked_q    <= 1'b0;
      locked_out_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      digit_count_q <= digit_count_d;
      fail_count_q  <= fail_count_d;
      mismatch_q    <= mismatch_d;
      fail_q        <= fail_d;
      unlocked_q    <= unlocked_d;
      locked_out_q  <= locked_out_d;
    end
  end

  assign bus.unlocked    = unlocked_q;
  assign bus.fail        = fail_q;
  assign bus.locked_out  = locked_out_q;
  assign bus.digit_count = digit_count_q;
  assign bus.fail_count  = fail_count_q;

endmodule

// File: tb/tb_passcode_fsm.sv
// Bench for passcode_fsm: directed scenarios plus random key traffic, all
// checked every cycle against a queue-based model of the entry rules.
module tb_passcode_fsm;

  localparam int         CODE_LEN       = 4;
  localparam logic [7:0] CODE           = 8'b10_00_01_11;
  localparam int         MAX_FAIL       = 3;
  localparam int         UNLOCK_CYCLES  = 16;
  localparam int         LOCK_CYCLES    = 32;
  localparam int         TIMEOUT_CYCLES = 64;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  passcode_if bus();

  passcode_fsm #(
    .CODE_LEN       (CODE_LEN),
    .CODE           (CODE),
    .MAX_FAIL       (MAX_FAIL),
    .UNLOCK_CYCLES  (UNLOCK_CYCLES),
    .LOCK_CYCLES    (LOCK_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_ENTRY, M_OPEN, M_LOCK} mode_t;
  mode_t m_mode   = M_ENTRY;
  int    m_digits[$];
  int    m_idle   = 0;
  int    m_hold   = 0;
  int    m_fc     = 0;
  bit    m_fail   = 1'b0;

  function automatic int code_digit(input int i);
    return int'((CODE >> (2 * i)) & 8'h3);
  endfunction

  function automatic int key_index(input logic [3:0] kp);
    int n = 0;
    int idx = -1;
    for (int b = 0; b < 4; b++) begin
      if (kp[b]) begin
        n++;
        idx = b;
      end
    end
    return (n == 1) ? idx : -1;
  endfunction

  task automatic model_step();
    bit ok;
    m_fail = 1'b0;
    if (clr) begin
      m_mode = M_ENTRY;
      m_digits.delete();
      m_idle = 0;
      m_hold = 0;
      m_fc   = 0;
    end else begin
      case (m_mode)
        M_ENTRY: begin
          if (bus.key_pulse != 4'd0) begin
            m_digits.push_back(key_index(bus.key_pulse));
            m_idle = 0;
            if (m_digits.size() == CODE_LEN) begin
              ok = 1'b1;
              foreach (m_digits[i]) if (m_digits[i] != code_digit(i)) ok = 1'b0;
              m_digits.delete();
              if (ok) begin
                m_mode = M_OPEN;
                m_hold = 0;
                m_fc   = 0;
              end else begin
                m_fail = 1'b1;
                m_fc++;
                if (m_fc == MAX_FAIL) begin
                  m_mode = M_LOCK;
                  m_hold = 0;
                end
              end
            end
          end else if (m_digits.size() > 0) begin
            m_idle++;
            if (m_idle == TIMEOUT_CYCLES) begin
              m_digits.delete();
              m_idle = 0;
            end
          end
        end
        M_OPEN: begin
          m_hold++;
          if (m_hold == UNLOCK_CYCLES) m_mode = M_ENTRY;
        end
        default: begin
          m_hold++;
          if (m_hold == LOCK_CYCLES) begin
            m_mode = M_ENTRY;
            m_fc   = 0;
          end
        end
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (cmp_on) begin
      check("cyc_unlocked",    int'(bus.unlocked),    int'(m_mode == M_OPEN));
      check("cyc_locked_out",  int'(bus.locked_out),  int'(m_mode == M_LOCK));
      check("cyc_fail",        int'(bus.fail),        int'(m_fail));
      check("cyc_digit_count", int'(bus.digit_count), m_digits.size());
      check("cyc_fail_count",  int'(bus.fail_count),  m_fc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic press(input logic [3:0] kp, input int gap);
    bus.key_pulse = kp;
    @(negedge clk);
    bus.key_pulse = 4'd0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic enter(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
    press(a, 1);
    press(b, 1);
    press(c, 1);
    press(d, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.unlocked || bus.locked_out) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_bound", int'(n < 100), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_unlocked"},    int'(bus.unlocked),    0);
    check({tag, "_fail"},        int'(bus.fail),        0);
    check({tag, "_locked_out"},  int'(bus.locked_out),  0);
    check({tag, "_digit_count"}, int'(bus.digit_count), 0);
    check({tag, "_fail_count"},  int'(bus.fail_count),  0);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    int n;
    int r;
    clr           = 1'b1;
    bus.key_pulse = 4'd0;
    repeat (3) @(negedge clk);
    clr    = 1'b0;
    cmp_on = 1'b1;
    check_all_zero("reset");

    // correct code, measure unlock duration
    enter(4'h8, 4'h2, 4'h1, 4'h4);
    check("ok_unlocked", int'(bus.unlocked), 1);
    check("ok_digit_count", int'(bus.digit_count), 0);
    check("ok_fail_count", int'(bus.fail_count), 0);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.unlocked) break;
      n++;
    end
    check("unlock_len", n, 16);

    // wrong then correct
    enter(4'h8, 4'h2, 4'h1, 4'h2);
    check("wrong_fail", int'(bus.fail), 1);
    check("wrong_fail_count", int'(bus.fail_count), 1);
    @(negedge clk);
    check("wrong_fail_pulse_end", int'(bus.fail), 0);
    enter(4'h8, 4'h2, 4'h1, 4'h4);
    check("retry_unlocked", int'(bus.unlocked), 1);
    check("retry_fail_count", int'(bus.fail_count), 0);
    wait_idle();

    // lockout, keys hammered during lockout are ignored
    enter(4'h1, 4'h1, 4'h1, 4'h1);
    enter(4'h2, 4'h2, 4'h2, 4'h2);
    enter(4'h4, 4'h4, 4'h4, 4'h4);
    check("lock_fail", int'(bus.fail), 1);
    check("lock_locked_out", int'(bus.locked_out), 1);
    check("lock_fail_count", int'(bus.fail_count), 3);
    n = 1;
    for (int i = 0; i < 60; i++) begin
      bus.key_pulse = (i % 2 == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      @(negedge clk);
      if (!bus.locked_out) break;
      check("lock_digit_count", int'(bus.digit_count), 0);
      n++;
    end
    bus.key_pulse = 4'd0;
    check("lock_len", n, 32);
    check("after_lock_fail_count", int'(bus.fail_count), 0);
    enter(4'h8, 4'h2, 4'h1, 4'h4);
    check("after_lock_unlocked", int'(bus.unlocked), 1);
    wait_idle();

    // multi-hot second digit
    enter(4'h8, 4'h3, 4'h1, 4'h4);
    check("multi_fail", int'(bus.fail), 1);
    check("multi_unlocked", int'(bus.unlocked), 0);
    enter(4'h8, 4'h2, 4'h1, 4'h4);
    wait_idle();

    // idle timeout discards a partial entry
    press(4'h8, 1);
    press(4'h2, 0);
    repeat (63) @(negedge clk);
    check("to_before", int'(bus.digit_count), 2);
    @(negedge clk);
    check("to_digit_count", int'(bus.digit_count), 0);
    check("to_fail", int'(bus.fail), 0);
    enter(4'h8, 4'h2, 4'h1, 4'h4);
    check("to_unlocked", int'(bus.unlocked), 1);
    wait_idle();

    // key on the expiry cycle wins over the timeout
    press(4'h8, 1);
    press(4'h2, 0);
    repeat (63) @(negedge clk);
    press(4'h1, 0);
    check("to_edge_digit_count", int'(bus.digit_count), 3);
    press(4'h4, 0);
    check("to_edge_unlocked", int'(bus.unlocked), 1);
    wait_idle();

    // reset during partial entry, UNLOCKED and LOCKOUT
    press(4'h8, 1);
    press(4'h2, 0);
    pulse_clr();
    check_all_zero("clr_entry");
    enter(4'h8, 4'h2, 4'h1, 4'h4);
    repeat (4) @(negedge clk);
    pulse_clr();
    check_all_zero("clr_unlocked");
    enter(4'h1, 4'h1, 4'h1, 4'h1);
    enter(4'h1, 4'h1, 4'h1, 4'h1);
    enter(4'h1, 4'h1, 4'h1, 4'h1);
    repeat (3) @(negedge clk);
    pulse_clr();
    check_all_zero("clr_lockout");

    // random traffic biased toward the correct next digit
    for (int c = 0; c < 4000; c++) begin
      r = int'($urandom_range(0, 99));
      if (r < 1) begin
        bus.key_pulse = 4'd0;
        pulse_clr();
      end else if (r < 4) begin
        bus.key_pulse = 4'd0;
        repeat ($urandom_range(50, 80)) @(negedge clk);
      end else if (r < 50) begin
        bus.key_pulse = 4'd0;
        @(negedge clk);
      end else if (r < 85) begin
        bus.key_pulse = 4'(1 << code_digit(m_digits.size() % CODE_LEN));
        @(negedge clk);
      end else begin
        bus.key_pulse = 4'($urandom_range(1, 15));
        @(negedge clk);
      end
    end
    bus.key_pulse = 4'd0;
    repeat (2) @(negedge clk);
    cmp_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
